vga_sync_to_count: RTL and testbench

//  Receive-side mate of the VGA column/row counter. Takes incoming HSync/VSync,

---
 rtl/vga_sync_to_count_if.sv | 31 +++
 rtl/vga_sync_to_count.sv | 171 +++++++++++++++++
 tb/tb_vga_sync_to_count.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_to_count_if.sv
// Sync inputs and recovered coordinate outputs for vga_sync_to_count.
// master = video source side, slave = the recovery block.
interface vga_sync_to_count_if;
  logic       i_HSync;
  logic       i_VSync;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic       o_Locked;
  logic       o_Frame_Start;
  logic       o_Sync_Err;

  modport master (
    output i_HSync,
    output i_VSync,
    input  o_Col_Count,
    input  o_Row_Count,
    input  o_Locked,
    input  o_Frame_Start,
    input  o_Sync_Err
  );

  modport slave (
    input  i_HSync,
    input  i_VSync,
    output o_Col_Count,
    output o_Row_Count,
    output o_Locked,
    output o_Frame_Start,
    output o_Sync_Err
  );
endinterface

// File: rtl/vga_sync_to_count.sv
// Recovers column/row counts from incoming HSync/VSync and reports lock.
// Sync edges load the counters on the same clock they are sampled.
module vga_sync_to_count #(
  parameter int TOTAL_COLS   = 800,
  parameter int TOTAL_ROWS   = 525,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 490,
  parameter bit SYNC_ACTIVE  = 1'b0,
  parameter int LOCK_FRAMES  = 2,
  parameter int TIMEOUT      = 1600
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  vga_sync_to_count_if.slave sif
);

  localparam logic [9:0]  COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]  H_START  = 10'(H_SYNC_START);
  localparam logic [9:0]  V_START  = 10'(V_SYNC_START);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [10:0] TO_MAX   = 11'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    VERIFY,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  col_q, col_d;
  logic [9:0]  row_q, row_d;
  logic [9:0]  col_p, row_p;
  logic [3:0]  frame_q, frame_d;
  logic [10:0] to_q, to_d;
  logic        hs_hist_q, vs_hist_q;
  logic        locked_q;
  logic        fstart_q, fstart_d;
  logic        err_q, err_d;
  logic        h_edge, v_edge;
  logic        col_wrap, row_wrap;
  logic        mismatch, timeout;

  assign h_edge = (sif.i_HSync == SYNC_ACTIVE) &&
                  (hs_hist_q != SYNC_ACTIVE);
  assign v_edge = (sif.i_VSync == SYNC_ACTIVE) &&
                  (vs_hist_q != SYNC_ACTIVE);

  // Free-run prediction: what the counters would do with no sync edge
  always_comb begin
    col_wrap = (col_q == COL_LAST);
    row_wrap = (row_q == ROW_LAST);
    col_p    = col_wrap ? 10'd0 : col_q + 10'd1;
    row_p    = row_q;
    if (col_wrap) begin
      row_p = row_wrap ? 10'd0 : row_q + 10'd1;
    end
  end

  assign mismatch = (h_edge && (col_p != H_START)) ||
                    (v_edge && (row_p != V_START));

  // Clocks since the last HSync edge, saturating at the limit
  always_comb begin
    to_d = to_q;
    if (h_edge) begin
      to_d = 11'd0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + 11'd1;
    end
  end

  assign timeout = (to_d == TO_MAX);

  // Next state, counter loads and event pulses
  always_comb begin
    state_d  = state_q;
    col_d    = h_edge ? H_START : col_p;
    row_d    = v_edge ? V_START : row_p;
    frame_d  = frame_q;
    err_d    = 1'b0;
    fstart_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        col_d = 10'd0;
        row_d = 10'd0;
        if (h_edge) begin
          state_d = ALIGN;
          col_d   = H_START;
        end
      end
      ALIGN: begin
        if (timeout) begin
          state_d = IDLE;
          col_d   = 10'd0;
          row_d   = 10'd0;
        end else if (v_edge) begin
          state_d = VERIFY;
          frame_d = 4'd0;
        end
      end
      VERIFY: begin
        if (timeout) begin
          state_d = IDLE;
          col_d   = 10'd0;
          row_d   = 10'd0;
          err_d   = 1'b1;
        end else if (mismatch) begin
          state_d = ALIGN;
          frame_d = 4'd0;
          err_d   = 1'b1;
        end else if (v_edge) begin
          frame_d = frame_q + 4'd1;
          if (frame_d == LOCK_N) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_d = IDLE;
          col_d   = 10'd0;
          row_d   = 10'd0;
          err_d   = 1'b1;
        end else if (mismatch) begin
          state_d = ALIGN;
          frame_d = 4'd0;
          err_d   = 1'b1;
        end else begin
          fstart_d = col_wrap && row_wrap &&
                     !h_edge && !v_edge;
        end
      end
    endcase
  end

  // State, counters, sync history and registered outputs
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      col_q     <= 10'd0;
      row_q     <= 10'd0;
      frame_q   <= 4'd0;
      to_q      <= 11'd0;
      hs_hist_q <= ~SYNC_ACTIVE;
      vs_hist_q <= ~SYNC_ACTIVE;
      locked_q  <= 1'b0;
      fstart_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      frame_q   <= frame_d;
      to_q      <= to_d;
      hs_hist_q <= sif.i_HSync;
      vs_hist_q <= sif.i_VSync;
      locked_q  <= (state_q == LOCKED);
      fstart_q  <= fstart_d;
      err_q     <= err_d;
    end
  end

  assign sif.o_Col_Count   = col_q;
  assign sif.o_Row_Count   = row_q;
  assign sif.o_Locked      = locked_q;
  assign sif.o_Frame_Start = fstart_q;
  assign sif.o_Sync_Err    = err_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count on a reduced 20x12 raster.
// Reference counts rc/rr are what the DUT should show after each edge.
module tb_vga_sync_to_count;
  localparam int TC  = 20;
  localparam int TR  = 12;
  localparam int HSS = 14;
  localparam int VSS = 9;
  localparam int TO  = 40;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   rc, rr, shift;
  bit   hold;

  vga_sync_to_count_if sif ();

  vga_sync_to_count #(
    .TOTAL_COLS   (TC),
    .TOTAL_ROWS   (TR),
    .H_SYNC_START (HSS),
    .V_SYNC_START (VSS),
    .SYNC_ACTIVE  (1'b0),
    .LOCK_FRAMES  (2),
    .TIMEOUT      (TO)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .sif   (sif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs,
                       input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic hs, input logic vs);
    @(negedge clk);
    sif.i_HSync = hs;
    sif.i_VSync = vs;
    @(posedge clk);
    #1;
  endtask

  // One clock of the reference generator: syncs lead the count they load
  task automatic tick();
    int   nc, nr;
    logic hs_a;
    @(negedge clk);
    nc = (rc == TC - 1) ? 0 : rc + 1;
    nr = (rc == TC - 1) ? ((rr == TR - 1) ? 0 : rr + 1) : rr;
    hs_a = (nc >= HSS - shift) && (nc <= HSS + 2 - shift);
    sif.i_HSync = (hs_a && !hold) ? 1'b0 : 1'b1;
    sif.i_VSync = (nr == VSS || nr == VSS + 1) ? 1'b0 : 1'b1;
    @(posedge clk);
    rc = nc;
    rr = nr;
    #1;
  endtask

  function automatic int col();
    return int'(sif.o_Col_Count);
  endfunction

  function automatic int row();
    return int'(sif.o_Row_Count);
  endfunction

  initial begin
    int t, bad, n_fs, last_fs, first_fs, gap;
    rst = 1'b1;
    sif.i_HSync = 1'b1;
    sif.i_VSync = 1'b1;
    rc = 0; rr = 0; shift = 0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_col", col(), 0);
    check("rst_row", row(), 0);
    check("rst_locked", int'(sif.o_Locked), 0);
    check("rst_fstart", int'(sif.o_Frame_Start), 0);
    check("rst_err", int'(sif.o_Sync_Err), 0);
    rst = 1'b0;

    // Simultaneous edges and row-wrap override
    drive(1'b0, 1'b1);
    check("align_col", col(), HSS);
    check("align_row", row(), 0);
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    check("both_col", col(), HSS);
    check("both_row", row(), VSS);
    repeat (5) drive(1'b1, 1'b1);
    check("pre_wrap_col", col(), TC - 1);
    drive(1'b1, 1'b0);
    check("wrap_col", col(), 0);
    check("wrap_row_override", row(), VSS);
    check("verify_mismatch_err", int'(sif.o_Sync_Err), 1);
    drive(1'b1, 1'b1);
    check("err_one_pulse", int'(sif.o_Sync_Err), 0);

    rst = 1'b1;
    drive(1'b1, 1'b1);
    rst = 1'b0;
    rc = 0; rr = 0;

    // Acquire lock from a clean raster
    t = 0; bad = 0;
    while (!sif.o_Locked && t < 2000) begin
      tick(); t++;
      if (sif.o_Sync_Err) bad++;
    end
    check("lock_time", t, 661);
    check("acquire_no_err", bad, 0);

    // Tracking and frame start while locked
    bad = 0; n_fs = 0; last_fs = -1; first_fs = -1; gap = 0;
    for (int i = 0; i < 480; i++) begin
      tick(); t++;
      if (col() != rc || row() != rr) bad++;
      if (!sif.o_Locked || sif.o_Sync_Err) bad++;
      if (sif.o_Frame_Start) begin
        n_fs++;
        if (col() != 0 || row() != 0) bad++;
        if (last_fs >= 0) gap = t - last_fs;
        else first_fs = t;
        last_fs = t;
      end
    end
    check("track", bad, 0);
    check("fs_count", n_fs, 2);
    check("fs_first", first_fs, 720);
    check("fs_gap", gap, 240);

    // One HS pulse three clocks early
    t = 0;
    while (!(rr == 2 && rc == 5) && t < 1000) begin
      tick(); t++;
    end
    shift = 3;
    repeat (6) tick();
    check("shift_err", int'(sif.o_Sync_Err), 1);
    check("shift_col", col(), HSS);
    tick();
    check("shift_unlock", int'(sif.o_Locked), 0);
    check("shift_err_once", int'(sif.o_Sync_Err), 0);
    repeat (5) tick();
    shift = 0;
    t = 6; bad = 0;
    while (!sif.o_Locked && t < 2000) begin
      tick(); t++;
      if (sif.o_Sync_Err) bad++;
    end
    check("relock_time", t, 610);
    check("relock_no_err", bad, 0);

    // HSync held inactive until timeout
    while (rc != 14) tick();
    hold = 1'b1;
    bad = 0;
    repeat (TO - 1) begin
      tick();
      if (sif.o_Sync_Err || !sif.o_Locked) bad++;
    end
    check("hold_quiet", bad, 0);
    tick();
    check("to_err", int'(sif.o_Sync_Err), 1);
    check("to_col", col(), 0);
    check("to_row", row(), 0);
    tick();
    check("to_unlock", int'(sif.o_Locked), 0);
    bad = 0;
    repeat (30) begin
      tick();
      if (col() != 0 || row() != 0) bad++;
      if (sif.o_Locked || sif.o_Sync_Err) bad++;
    end
    check("idle_hold", bad, 0);
    while (rc != 0) tick();
    hold = 1'b0;
    repeat (13) tick();
    check("idle_pre_edge", col(), 0);
    tick();
    check("reacq_col", col(), HSS);
    check("reacq_row", row(), 0);

    // Reset for one clock mid-frame while locked
    t = 0;
    while (!sif.o_Locked && t < 2000) begin
      tick(); t++;
    end
    check("locked_before_rst", int'(sif.o_Locked), 1);
    t = 0;
    while (!(rr == 2 && rc == 4) && t < 1000) begin
      tick(); t++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_col", col(), 0);
    check("mrst_row", row(), 0);
    check("mrst_locked", int'(sif.o_Locked), 0);
    check("mrst_fstart", int'(sif.o_Frame_Start), 0);
    check("mrst_err", int'(sif.o_Sync_Err), 0);
    t = 0;
    while (!sif.o_Locked && t < 2000) begin
      tick(); t++;
    end
    check("mrst_relock_time", t, 616);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
